// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, waits out the memory read latency,
// captures the instruction word and presents it over a valid/ready handshake.
module fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MEM_LAT  = 2,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        busy
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       inst_q, inst_d;
    logic [63:0]       inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;

    logic              hs;
    logic              capture;
    logic [CNT_W-1:0]  cnt_dec;
    logic [63:0]       redirect_tgt;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        capture   = 1'b0;

        hs           = valid_q & inst_ready;
        cnt_dec      = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        redirect_tgt = redirect_pc & ~64'h3;

        case (state_q)
            S_IDLE: begin
                // redirect and start may land on the same edge: fetch begins at the new PC
                if (redirect) begin
                    pc_d = redirect_tgt;
                end
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    valid_d = 1'b0;
                    cnt_d   = CNT_INIT;
                end else if (halt) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_dec;
                end else begin
                    capture = 1'b1;
                end
            end
            S_HOLD: begin
                // the next address is already on imem_addr, so cnt keeps running while held
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    valid_d = 1'b0;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end else if (halt) begin
                    if (hs) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end else if (hs) begin
                    if (cnt_q == '0) begin
                        capture = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        cnt_d   = cnt_dec;
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            inst_d    = imem_data;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + PC_STEP;
            cnt_d     = CNT_INIT;
            state_d   = S_HOLD;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = valid_q;
    assign busy       = (state_q != S_IDLE);

endmodule
